// File: rtl/ipg_pkg.sv
// Shared definitions for the IPG transmit path: block-type codes, chunk
// position codes, arbiter FSM states and credit counter width.
package ipg_pkg;

    localparam int CREDIT_W = 4;

    localparam logic [7:0] BT_REQ_FIRST = 8'h2a;
    localparam logic [7:0] BT_REQ_MID   = 8'h1a;
    localparam logic [7:0] BT_REQ_LAST  = 8'h0a;
    localparam logic [7:0] BT_RPL_FIRST = 8'h2b;
    localparam logic [7:0] BT_RPL_MID   = 8'h1b;
    localparam logic [7:0] BT_RPL_LAST  = 8'h0b;

    localparam logic [3:0] POS_FIRST = 4'd2;
    localparam logic [3:0] POS_MID   = 4'd1;
    localparam logic [3:0] POS_LAST  = 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ_MSG = 2'd1,
        ST_RPL_MSG = 2'd2
    } arb_state_e;

    typedef enum logic {
        SRC_REQ = 1'b0,
        SRC_RPL = 1'b1
    } src_e;

    // Chunk position lives in the upper nibble of the block type.
    function automatic logic [3:0] bt_pos(input logic [7:0] bt);
        return bt[7:4];
    endfunction

endpackage

// File: rtl/ipg_credit_ctr.sv
// Saturating up/down credit counter: starts at INIT, never exceeds INIT,
// never underflows; simultaneous increment and decrement cancel.
module ipg_credit_ctr
    import ipg_pkg::*;
#(
    parameter int INIT = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                inc_i,
    input  logic                dec_i,
    output logic [CREDIT_W-1:0] count_o
);

    localparam logic [CREDIT_W-1:0] INIT_V = CREDIT_W'(INIT);

    logic [CREDIT_W-1:0] count_q;
    logic [CREDIT_W-1:0] count_d;

    // Next credit value.
    always_comb begin
        count_d = count_q;
        if (inc_i && !dec_i) begin
            if (count_q < INIT_V) begin
                count_d = count_q + CREDIT_W'(1);
            end else begin
                count_d = count_q;
            end
        end else if (dec_i && !inc_i) begin
            if (count_q != CREDIT_W'(0)) begin
                count_d = count_q - CREDIT_W'(1);
            end else begin
                count_d = count_q;
            end
        end else begin
            count_d = count_q;
        end
    end

    // Credit register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= INIT_V;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/ipg_tx_arb.sv
// IPG transmit-slot arbiter: atomic message grant between request and reply
// sources, credit-gated requests. Optional IPG_TXARB_BACK2BACK_EN removes the IDLE gap.
module ipg_tx_arb
    import ipg_pkg::*;
#(
    parameter int CREDIT_INIT = 6,
    parameter int DATA_WIDTH  = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] req_data,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [DATA_WIDTH-1:0] rpl_data,
    input  logic                  rpl_valid,
    output logic                  rpl_ready,
    input  logic                  credit_ret,
    output logic [DATA_WIDTH-1:0] tx_ipg_data,
    output logic                  tx_ipg_valid,
    input  logic                  tx_ipg_ready,
    output logic [CREDIT_W-1:0]   credits,
    output logic                  err_frame
);

    arb_state_e            state_q, state_d;
    src_e                  last_grant_q, last_grant_d;
    logic                  err_q, err_d;
    logic                  tx_valid_q;
    logic [DATA_WIDTH-1:0] tx_data_q;
    logic                  fwd_s;
    logic [DATA_WIDTH-1:0] fwd_data_s;
    logic                  cred_dec_s;
    logic [3:0]            req_pos_s, rpl_pos_s;
    logic                  out_free_s;
    logic                  req_elig_s, rpl_elig_s;
    logic                  pick_req_s, pick_rpl_s;
    logic                  b2b_to_req_s, b2b_to_rpl_s;
    logic                  first_pend_s;

    assign req_pos_s  = bt_pos(req_data[7:0]);
    assign rpl_pos_s  = bt_pos(rpl_data[7:0]);
    assign out_free_s = ~tx_valid_q | tx_ipg_ready;
    assign req_elig_s = req_valid & (req_pos_s == POS_FIRST) & (credits != CREDIT_W'(0));
    assign rpl_elig_s = rpl_valid & (rpl_pos_s == POS_FIRST);
    assign pick_req_s = req_elig_s & (~rpl_elig_s | (last_grant_q == SRC_RPL));
    assign pick_rpl_s = rpl_elig_s & ~pick_req_s;

`ifdef IPG_TXARB_BACK2BACK_EN
    // Entered a MSG state straight from the other source's LAST: its FIRST is still due.
    logic pend_q;

    assign b2b_to_req_s = req_elig_s;
    assign b2b_to_rpl_s = rpl_elig_s;
    assign first_pend_s = pend_q;

    // Pending-FIRST flag for back-to-back grants.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q <= 1'b0;
        end else if ((state_q == ST_REQ_MSG && state_d == ST_RPL_MSG) ||
                     (state_q == ST_RPL_MSG && state_d == ST_REQ_MSG)) begin
            pend_q <= 1'b1;
        end else if (fwd_s) begin
            pend_q <= 1'b0;
        end else begin
            pend_q <= pend_q;
        end
    end
`else
    assign b2b_to_req_s = 1'b0;
    assign b2b_to_rpl_s = 1'b0;
    assign first_pend_s = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_ready && req_pos_s == POS_FIRST) begin
                    state_d = ST_REQ_MSG;
                end else if (rpl_ready && rpl_pos_s == POS_FIRST) begin
                    state_d = ST_RPL_MSG;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ_MSG: begin
                if (req_ready && req_pos_s == POS_LAST) begin
                    state_d = b2b_to_rpl_s ? ST_RPL_MSG : ST_IDLE;
                end else begin
                    state_d = ST_REQ_MSG;
                end
            end
            ST_RPL_MSG: begin
                if (rpl_ready && rpl_pos_s == POS_LAST) begin
                    state_d = b2b_to_req_s ? ST_REQ_MSG : ST_IDLE;
                end else begin
                    state_d = ST_RPL_MSG;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: source handshakes, forwarding, credit use and framing errors.
    always_comb begin
        req_ready    = 1'b0;
        rpl_ready    = 1'b0;
        fwd_s        = 1'b0;
        fwd_data_s   = req_data;
        cred_dec_s   = 1'b0;
        err_d        = 1'b0;
        last_grant_d = last_grant_q;
        case (state_q)
            ST_IDLE: begin
                if (!out_free_s) begin
                    fwd_s = 1'b0;
                end else if (pick_req_s) begin
                    req_ready    = 1'b1;
                    fwd_s        = 1'b1;
                    cred_dec_s   = 1'b1;
                    last_grant_d = SRC_REQ;
                end else if (pick_rpl_s) begin
                    rpl_ready    = 1'b1;
                    fwd_s        = 1'b1;
                    fwd_data_s   = rpl_data;
                    last_grant_d = SRC_RPL;
                end else if (rpl_valid && rpl_pos_s != POS_FIRST) begin
                    rpl_ready = 1'b1;
                    err_d     = 1'b1;
                end else if (req_valid && req_pos_s != POS_FIRST) begin
                    req_ready = 1'b1;
                    err_d     = 1'b1;
                end else begin
                    fwd_s = 1'b0;
                end
            end
            ST_REQ_MSG: begin
                req_ready = out_free_s & (first_pend_s ? req_elig_s : req_valid);
                fwd_s     = req_ready;
                if (req_ready && req_pos_s == POS_FIRST) begin
                    cred_dec_s   = 1'b1;
                    err_d        = ~first_pend_s;
                    last_grant_d = SRC_REQ;
                end else begin
                    cred_dec_s = 1'b0;
                end
            end
            ST_RPL_MSG: begin
                rpl_ready  = out_free_s & (first_pend_s ? rpl_elig_s : rpl_valid);
                fwd_s      = rpl_ready;
                fwd_data_s = rpl_data;
                if (rpl_ready && rpl_pos_s == POS_FIRST) begin
                    err_d        = ~first_pend_s;
                    last_grant_d = SRC_RPL;
                end else begin
                    err_d = 1'b0;
                end
            end
            default: begin
                req_ready = 1'b0;
                rpl_ready = 1'b0;
            end
        endcase
    end

    // Output stage, round-robin pointer and error pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= SRC_RPL;
            err_q        <= 1'b0;
            tx_valid_q   <= 1'b0;
            tx_data_q    <= {DATA_WIDTH{1'b0}};
        end else begin
            last_grant_q <= last_grant_d;
            err_q        <= err_d;
            if (fwd_s) begin
                tx_valid_q <= 1'b1;
                tx_data_q  <= fwd_data_s;
            end else if (tx_ipg_ready) begin
                tx_valid_q <= 1'b0;
            end else begin
                tx_valid_q <= tx_valid_q;
            end
        end
    end

    ipg_credit_ctr #(
        .INIT (CREDIT_INIT)
    ) u_credit_ctr (
        .clk     (clk),
        .rst_n   (reset_n),
        .inc_i   (credit_ret),
        .dec_i   (cred_dec_s),
        .count_o (credits)
    );

    assign tx_ipg_data  = tx_data_q;
    assign tx_ipg_valid = tx_valid_q;
    assign err_frame    = err_q;

endmodule

// File: doc/ipg_tx_arb.md
# ipg_tx_arb

Arbiter and sequencer for the IPG transmit slot. It shares one PHY IPG chunk path between two chunk sources: the local read-request queue and the read-reply queue (the FakeDRAM `memq` output). Each multi-chunk message is granted atomically. Read requests are gated by credits that track free entries in the remote reply-generator address queue.

## Interface
- `CREDIT_INIT`, 6: credits at reset; equals the remote address-queue depth; legal range 1..15.
- `DATA_WIDTH`, 64: chunk width; bits [7:0] carry the block type.
- `clk` in 1: sole clock, rising edge.
- `reset_n` in 1: asynchronous assert, active-low; deassertion synchronous to `clk` is provided externally.
- `req_data` in 64: request-source chunk.
- `req_valid` in 1: request chunk present.
- `req_ready` out 1: request chunk accepted this cycle.
- `rpl_data` in 64: reply-source chunk.
- `rpl_valid` in 1: reply chunk present.
- `rpl_ready` out 1: reply chunk accepted this cycle.
- `credit_ret` in 1: one-cycle pulse; the remote side freed one address-queue entry.
- `tx_ipg_data` out 64: chunk to PHY.
- `tx_ipg_valid` out 1: `tx_ipg_data` is valid.
- `tx_ipg_ready` in 1: PHY consumes the chunk this cycle (IPG slot available).
- `credits` out 4: current credit count.
- `err_frame` out 1: one-cycle pulse on a framing violation.

## Operation
- Chunk position comes from the block-type upper nibble, `bt[7:4]`: 2 = FIRST, 1 = MID, 0 = LAST. Request chunks use types 2a/1a/0a; reply chunks use 2b/1b/0b. The low nibble is not checked.
- Output stage: one-entry register (`tx_ipg_valid`, `tx_ipg_data`).
  - `out_free = !tx_ipg_valid | tx_ipg_ready`.
  - Source acceptance requires `out_free`. Accepted chunks load the register unmodified.
- FSM states:
  - IDLE: no message in flight.
    - Request is eligible when `req_valid`, `req_data[7:4]==2`, and `credits!=0`.
    - Reply is eligible when `rpl_valid` and `rpl_data[7:4]==2`.
    - With `out_free` and at least one eligible source, grant one source and accept its FIRST chunk.
    - Go to REQ_MSG or RPL_MSG accordingly, and set `last_grant` to that source.
  - REQ_MSG / RPL_MSG: only the granted source can get ready. `ready = valid & out_free`.
    - An accepted chunk with `bt[7:4]==0` returns the FSM to IDLE.
    - MID chunks stay in the state.
    - The other source stalls regardless of its state.
- Arbitration when both sources are eligible: round-robin. The source not equal to `last_grant` wins. `last_grant` resets to reply, so the first tie goes to request.
- Credits:
  - Decrement by 1 when a request FIRST chunk is accepted.
  - Increment by 1 on `credit_ret`.
  - Both events in the same cycle: no change.
  - Increment saturates at `CREDIT_INIT`.
  - Decrement at 0 cannot occur because eligibility is gated.
  - Credits gate only the start of a message. An in-flight request message always completes.
- Framing errors. Each case pulses `err_frame` for one cycle.
  - In IDLE, a non-FIRST chunk at the head of a source: the chunk is accepted and discarded, not forwarded, when `out_free`, and the FSM stays in IDLE. Reply has priority for discard if both sources are bad.
  - In a MSG state, a FIRST chunk from the granted source: it is forwarded, the message restarts, and the FSM stays in the MSG state. For a request, a credit is also decremented.
- Reset: FSM to IDLE, `tx_ipg_valid` 0, `tx_ipg_data` 0, `credits` `CREDIT_INIT`, `last_grant` reply, `err_frame` 0.
  - Reset mid-message drops the in-flight message. The sources are reset by the same `reset_n`.

## Timing
- `req_ready` / `rpl_ready` are combinational from valid, data[7:4], FSM state, credits, and `out_free`.
- Latency is one cycle: a chunk accepted at edge N appears on `tx_ipg_data` after edge N.
- Full throughput is one chunk per cycle while `tx_ipg_ready` stays high.
- `tx_ipg_data` and `tx_ipg_valid` are stable while `tx_ipg_valid & !tx_ipg_ready`.
- `credits` updates on the edge of the accepting or returning event.
- The grant switches in IDLE only, so there is at least one IDLE cycle between messages unless IPG_TXARB_BACK2BACK_EN is defined.
- `err_frame` is registered and is high in the cycle after the offending acceptance.

## Configuration
- `IPG_TXARB_BACK2BACK_EN`:
  - Defined: acceptance of a LAST chunk also runs the IDLE arbitration in the same cycle. If a FIRST chunk is eligible on the next cycle, the FSM enters the new MSG state directly with no IDLE bubble. Round-robin uses the just-finished source as `last_grant`.
  - Undefined: exactly one IDLE cycle after each LAST chunk.

## Structure
- Shared package `ipg_pkg`:
  - block-type constants BT_REQ_FIRST/MID/LAST (2a/1a/0a) and BT_RPL_FIRST/MID/LAST (2b/1b/0b);
  - position codes POS_FIRST=2, POS_MID=1, POS_LAST=0;
  - FSM state enum;
  - `CREDIT_W`=4.
- Sub-module `ipg_credit_ctr`: the saturating up/down credit counter, reusable for reply-side flow control.

## Test plan
1. Lone request message, `tx_ipg_ready`=1, stimulus 2a,1a,0a -> identical chunks on the output 1 cycle later, back-to-back; `credits` 6->5.
2. Request and reply FIRST chunks both valid from reset -> request message forwarded whole, then reply message; no interleave; next tie won by request.
3. Six request messages with no `credit_ret` -> `credits` reaches 0. The 7th request stalls while a reply message still proceeds. One `credit_ret` pulse -> the 7th request starts and `credits` returns to 0.
4. `credit_ret` in the same cycle as a request FIRST acceptance -> `credits` unchanged. `credit_ret` at 6 -> stays 6.
5. `tx_ipg_ready`=0 for 3 cycles mid-message -> output held stable; source `ready` low after the register fills; no chunk lost or duplicated.
6. Reply 1b presented in IDLE -> discarded and `err_frame` pulses. Then `reset_n` asserted mid-message -> outputs 0, `credits`=6, FSM in IDLE.
